// File: rtl/tt_um_hoene_protocol_check.sv
// Serial frame parity checker: counts FRAME_BITS strobed bits per frame, flags
// parity failures, reports aborted frames and keeps a sticky saturating error count.
module tt_um_hoene_protocol_check #(
  parameter int FRAME_BITS = 24,
  parameter bit PARITY_ODD = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_data,
  input  logic                 in_clk,
  input  logic                 in_sync,
  input  logic                 clear_err,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic                 frame_abort,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             parity_r;
  logic             parity_next_s;
  logic             last_bit_s;
  logic             fail_s;

  function automatic logic parity_update(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  // Decode the cycle in which the final (parity) bit of a frame is accepted.
  always_comb begin
    parity_next_s = parity_update(parity_r, in_data);
    last_bit_s    = 1'b0;
    fail_s        = 1'b0;
    if ((state_r == ACTIVE) && in_sync && in_clk && (bit_cnt_r == LAST_BIT)) begin
      last_bit_s = 1'b1;
      fail_s     = (parity_next_s != PARITY_ODD);
    end else begin
      last_bit_s = 1'b0;
      fail_s     = 1'b0;
    end
  end

  // Frame state machine, bit counter, running parity and per-frame pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= CNT_W'(0);
      parity_r    <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_abort <= 1'b0;
      case (state_r)
        IDLE: begin
          bit_cnt_r <= CNT_W'(0);
          parity_r  <= 1'b0;
          if (in_sync) begin
            state_r <= ACTIVE;
          end else begin
            state_r <= IDLE;
          end
        end
        ACTIVE: begin
          // A sync drop wins over a coincident strobe; the bit is discarded.
          if (!in_sync) begin
            bit_cnt_r <= CNT_W'(0);
            parity_r  <= 1'b0;
            if (bit_cnt_r != CNT_W'(0)) begin
              state_r     <= ABORT;
              frame_abort <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else if (in_clk) begin
            state_r <= ACTIVE;
            if (last_bit_s) begin
              frame_done  <= 1'b1;
              frame_error <= fail_s;
              bit_cnt_r   <= CNT_W'(0);
              parity_r    <= 1'b0;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              parity_r  <= parity_next_s;
            end
          end else begin
            state_r <= ACTIVE;
          end
        end
        ABORT: begin
          state_r   <= IDLE;
          bit_cnt_r <= CNT_W'(0);
          parity_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= CNT_W'(0);
          parity_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag and saturating failure counter; a failing frame beats clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error     <= 1'b0;
      err_count <= ERR_CNT_W'(0);
    end else if (fail_s) begin
      error <= 1'b1;
      if (clear_err) begin
        err_count <= ERR_CNT_W'(1);
      end else if (&err_count) begin
        err_count <= err_count;
      end else begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end else if (clear_err) begin
      error     <= 1'b0;
      err_count <= ERR_CNT_W'(0);
    end else begin
      error     <= error;
      err_count <= err_count;
    end
  end

endmodule

// File: doc/tt_um_hoene_protocol_check.md
TT_UM_HOENE_PROTOCOL_CHECK -- requirements
Module: tt_um_hoene_protocol_check

Interface
REQ-001 Parameter FRAME_BITS, default 24: bits per frame, including the final parity bit; legal values are 2..256.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Parameter ERR_CNT_W, default 8: width of the error counter.
REQ-004 clk  input  1: global clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 in_data  input  1: serial data bit, qualified by in_clk.
REQ-007 in_clk  input  1: bit strobe, one clk cycle wide per bit, synchronous to clk.
REQ-008 in_sync  input  1: stream valid; low means idle or abort.
REQ-009 clear_err  input  1: synchronous clear of the error output and err_count.
REQ-010 frame_done  output  1: one-cycle pulse at the end of every complete frame.
REQ-011 frame_error  output  1: one-cycle pulse, coincident with frame_done, when the parity check fails.
REQ-012 frame_abort  output  1: one-cycle pulse when in_sync drops mid-frame.
REQ-013 error  output  1: sticky error flag.
REQ-014 err_count  output  ERR_CNT_W: saturating count of failed frames.

Function
REQ-015 The block SHALL keep an internal bit counter, bit_cnt, of width clog2(FRAME_BITS), and a running parity register.
REQ-016 The state machine SHALL have three states: IDLE, ACTIVE and ABORT.
- IDLE -> ACTIVE when in_sync=1.
- ACTIVE -> ABORT when in_sync=0 and bit_cnt!=0.
- ACTIVE -> IDLE when in_sync=0 and bit_cnt==0.
- ABORT -> IDLE unconditionally after one cycle.
REQ-017 In IDLE and ABORT, bit_cnt and parity SHALL be held at 0, and in_clk SHALL be ignored.
REQ-018 In ACTIVE with in_clk=1 and bit_cnt<FRAME_BITS-1, the block SHALL set parity<=parity^in_data and bit_cnt<=bit_cnt+1.
REQ-019 In ACTIVE with in_clk=1 and bit_cnt==FRAME_BITS-1, the block SHALL:
- compute p=parity^in_data;
- pulse frame_done on the next cycle;
- pulse frame_error on the next cycle if p!=PARITY_ODD;
- wrap bit_cnt to 0 and reset parity to 0.
REQ-020 The first in_clk after entering ACTIVE SHALL be bit 0 of a frame, and back-to-back frames SHALL need no gap.
REQ-021 If in_clk and the falling edge of in_sync occur in the same cycle, the in_sync drop SHALL take priority and the bit SHALL be discarded.
REQ-022 On the ACTIVE->ABORT transition, the block SHALL drive frame_abort=1 for exactly one cycle, and the partial frame SHALL produce neither frame_done nor frame_error.
REQ-023 When frame_error pulses, error SHALL become 1, and err_count SHALL increment unless it is all ones, where it holds (saturates).
REQ-024 When clear_err=1 with no simultaneous failing frame, error and err_count SHALL become 0 on the next cycle.
REQ-025 When clear_err=1 coincides with a failing-frame evaluation, the block SHALL set error=1 and err_count=1.
REQ-026 error and err_count SHALL be unaffected by in_sync.
REQ-027 All outputs SHALL be registered, with a latency of 1 clk from the qualifying input cycle.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force:
- state=IDLE, bit_cnt=0, parity=0;
- frame_done=0, frame_error=0, frame_abort=0;
- error=0, err_count=0.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame without a frame_abort pulse.
REQ-030 After rst_n rises, the block SHALL resume in IDLE and obey REQ-016 from the first clk edge.

Verification (FRAME_BITS=8, PARITY_ODD=0, ERR_CNT_W=8)
REQ-031 in_sync=1, bits 1,1,0,0,0,0,0,0 -> frame_done pulse, frame_error=0, err_count=0.
REQ-032 Bits 1,0,0,0,0,0,0,0 -> frame_done and frame_error pulse in the same cycle, error=1, err_count=1.
REQ-033 300 consecutive failing frames -> err_count=255 and holds; error=1.
REQ-034 3 bits, then in_sync=0 in the same cycle as in_clk -> frame_abort pulses once, no frame_done; after in_sync=1, a valid frame passes cleanly.
REQ-035 err_count=5, then clear_err in the same cycle as a failing-frame evaluation -> error=1, err_count=1; clear_err alone afterwards -> error=0, err_count=0.
REQ-036 rst_n=0 after 4 bits, release, then a valid 8-bit frame -> all outputs 0 during reset; exactly one frame_done, no frame_error, no frame_abort.
